path_history_recovery: RTL and testbench

PATH_HISTORY_RECOVERY -- requirements
Module: path_history_recovery

---
 rtl/path_history_recovery.sv | 92 +++++++++
 tb/tb_path_history_recovery.sv | 109 ++++++++++
 2 files changed

// File: rtl/path_history_recovery.sv
// path_history_recovery: speculative/committed branch path history with mispredict recovery.
// Build option: define PH_RECOVERY_STATS_EN to enable the saturating mispredict counter.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   pred_valid, pred_taken  - predicted branch from the front end
//   pred_ready, pred_tag    - prediction accepted / checkpoint slot (write pointer)
//   res_valid, res_taken    - in-order resolution of the oldest in-flight branch
//   spec_hist, arch_hist    - speculative and committed path histories
//   inflight                - unresolved prediction count
//   flush                   - high during the single recovery cycle
//   res_err                 - sticky: resolution arrived with nothing in flight
//   mispred_cnt             - mispredict count (tied to 0 unless stats enabled)
module path_history_recovery #(
   parameter int HIST_W = 12,
   parameter int DEPTH  = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       pred_valid,
   input  logic                       pred_taken,
   output logic                       pred_ready,
   output logic [$clog2(DEPTH)-1:0]   pred_tag,
   input  logic                       res_valid,
   input  logic                       res_taken,
   output logic [HIST_W-1:0]          spec_hist,
   output logic [HIST_W-1:0]          arch_hist,
   output logic [$clog2(DEPTH):0]     inflight,
   output logic                       flush,
   output logic                       res_err,
   output logic [15:0]                mispred_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef enum logic {RUN, RECOVER} state_t;
   state_t state, state_nx;
   logic [DEPTH-1:0] fifo;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic accept, resolve, mispred;
   assign pred_ready = (state == RUN) && (inflight < FULL);
   assign accept     = pred_valid && pred_ready;
   assign resolve    = res_valid && (inflight != '0) && (state == RUN);
   assign mispred    = resolve && (res_taken != fifo[rd_ptr]);
   assign flush      = (state == RECOVER);
   assign pred_tag   = wr_ptr;
   always_ff @(posedge clock) begin
      if (reset) state <= RUN;
      else       state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      state_nx = (state == RECOVER) ? RUN : (mispred ? RECOVER : RUN);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         spec_hist <= '0;
         arch_hist <= '0;
         inflight  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         res_err   <= 1'b0;
         fifo      <= '0;
      end else begin
         if (accept && !mispred) begin
            fifo[wr_ptr] <= pred_taken;
            wr_ptr       <= wr_ptr + AW'(1);
         end
         if (resolve) begin
            arch_hist <= {res_taken, arch_hist[HIST_W-1:1]};
            rd_ptr    <= rd_ptr + AW'(1);
         end
         // A mispredict rebuilds speculation from the committed history including the
         // resolving outcome, and drops every younger entry plus any same-cycle accept.
         if (mispred) begin
            spec_hist <= {res_taken, arch_hist[HIST_W-1:1]};
            rd_ptr    <= wr_ptr;
            inflight  <= '0;
         end else begin
            if (accept) spec_hist <= {pred_taken, spec_hist[HIST_W-1:1]};
            inflight <= inflight + {{AW{1'b0}}, accept} - {{AW{1'b0}}, resolve};
         end
         if (res_valid && (state == RUN) && (inflight == '0)) res_err <= 1'b1;
      end
   end
`ifdef PH_RECOVERY_STATS_EN
   always_ff @(posedge clock) begin
      if (reset)                                  mispred_cnt <= '0;
      else if (mispred && mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
   end
`else
   assign mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_path_history_recovery.sv
// tb_path_history_recovery: directed table-driven bench for path_history_recovery.
module tb_path_history_recovery;
   logic        clock = 1'b0;
   logic        reset, pred_valid, pred_taken, res_valid, res_taken;
   logic        pred_ready, flush, res_err;
   logic [2:0]  pred_tag;
   logic [11:0] spec_hist, arch_hist;
   logic [3:0]  inflight;
   logic [15:0] mispred_cnt;
   int checks = 0;
   int fails  = 0;
`ifdef PH_RECOVERY_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif
   path_history_recovery #(.HIST_W(12), .DEPTH(8)) dut (
      .clock(clock), .reset(reset),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_ready(pred_ready), .pred_tag(pred_tag),
      .res_valid(res_valid), .res_taken(res_taken),
      .spec_hist(spec_hist), .arch_hist(arch_hist),
      .inflight(inflight), .flush(flush), .res_err(res_err),
      .mispred_cnt(mispred_cnt)
   );
   always #5 clock = ~clock;
   typedef struct {
      logic rst, pv, pt, rv, rt;
      logic [11:0] spec, arch;
      logic [3:0]  infl;
      logic        fl, rdy, err;
      logic [2:0]  tag;
      int          mp;
   } vec_t;
   vec_t v[16];
   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask
   task automatic drive(input logic r, input logic pv, input logic pt, input logic rv, input logic rt);
      @(negedge clock);
      reset = r; pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
      @(posedge clock);
      #1;
   endtask
   task automatic chk_all(input int idx, input logic [11:0] s, input logic [11:0] a, input logic [3:0] n,
                          input logic fl, input logic rd, input logic er, input logic [2:0] tg, input int mp);
      chk("spec_hist", idx, 32'(spec_hist), 32'(s));
      chk("arch_hist", idx, 32'(arch_hist), 32'(a));
      chk("inflight", idx, 32'(inflight), 32'(n));
      chk("flush", idx, 32'(flush), 32'(fl));
      chk("pred_ready", idx, 32'(pred_ready), 32'(rd));
      chk("res_err", idx, 32'(res_err), 32'(er));
      chk("pred_tag", idx, 32'(pred_tag), 32'(tg));
      chk("mispred_cnt", idx, 32'(mispred_cnt), (STATS != 0) ? mp : 0);
   endtask
   initial begin
      reset = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
      //          rst pv pt rv rt  spec     arch     infl fl rdy err tag mp
      v[0]  = '{1, 0, 0, 0, 0, 12'h000, 12'h000, 4'd0, 0, 1, 0, 3'd0, 0};
      v[1]  = '{0, 1, 1, 0, 0, 12'h800, 12'h000, 4'd1, 0, 1, 0, 3'd1, 0};
      v[2]  = '{0, 1, 1, 0, 0, 12'hC00, 12'h000, 4'd2, 0, 1, 0, 3'd2, 0};
      v[3]  = '{0, 1, 0, 0, 0, 12'h600, 12'h000, 4'd3, 0, 1, 0, 3'd3, 0};
      v[4]  = '{0, 0, 0, 1, 1, 12'h600, 12'h800, 4'd2, 0, 1, 0, 3'd3, 0};
      v[5]  = '{0, 0, 0, 1, 1, 12'h600, 12'hC00, 4'd1, 0, 1, 0, 3'd3, 0};
      v[6]  = '{0, 0, 0, 1, 0, 12'h600, 12'h600, 4'd0, 0, 1, 0, 3'd3, 0};
      v[7]  = '{0, 0, 0, 1, 0, 12'h600, 12'h600, 4'd0, 0, 1, 1, 3'd3, 0};
      v[8]  = '{1, 0, 0, 0, 0, 12'h000, 12'h000, 4'd0, 0, 1, 0, 3'd0, 0};
      v[9]  = '{0, 1, 1, 0, 0, 12'h800, 12'h000, 4'd1, 0, 1, 0, 3'd1, 0};
      v[10] = '{0, 1, 1, 0, 0, 12'hC00, 12'h000, 4'd2, 0, 1, 0, 3'd2, 0};
      v[11] = '{0, 1, 1, 1, 0, 12'h000, 12'h000, 4'd0, 1, 0, 0, 3'd2, 1};
      v[12] = '{0, 1, 1, 1, 1, 12'h000, 12'h000, 4'd0, 0, 1, 0, 3'd2, 1};
      v[13] = '{0, 1, 0, 0, 0, 12'h000, 12'h000, 4'd1, 0, 1, 0, 3'd3, 1};
      v[14] = '{0, 1, 1, 1, 0, 12'h800, 12'h000, 4'd1, 0, 1, 0, 3'd4, 1};
      v[15] = '{0, 0, 0, 1, 1, 12'h800, 12'h800, 4'd0, 0, 1, 0, 3'd4, 1};
      for (int i = 0; i < 16; i++) begin
         drive(v[i].rst, v[i].pv, v[i].pt, v[i].rv, v[i].rt);
         chk_all(i, v[i].spec, v[i].arch, v[i].infl, v[i].fl, v[i].rdy, v[i].err, v[i].tag, v[i].mp);
      end
      // Fill all eight slots, then try a ninth and resolve at full occupancy.
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 1, 1, 0, 0);
      chk_all(100, 12'hFF0, 12'h000, 4'd8, 0, 0, 0, 3'd0, 0);
      drive(0, 1, 0, 0, 0);
      chk_all(101, 12'hFF0, 12'h000, 4'd8, 0, 0, 0, 3'd0, 0);
      drive(0, 1, 0, 1, 1);
      chk_all(102, 12'hFF0, 12'h800, 4'd7, 0, 1, 0, 3'd0, 0);
      drive(0, 1, 0, 0, 0);
      chk_all(103, 12'h7F8, 12'h800, 4'd8, 0, 0, 0, 3'd1, 0);
      // Reset with five in flight and a concurrent accept and resolve.
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0);
      chk_all(104, 12'hF80, 12'h000, 4'd5, 0, 1, 0, 3'd5, 0);
      drive(1, 1, 1, 1, 1);
      chk_all(105, 12'h000, 12'h000, 4'd0, 0, 1, 0, 3'd0, 0);
      // Mispredict from reset: recovery lasts exactly one cycle.
      drive(0, 1, 1, 0, 0);
      drive(0, 1, 1, 0, 0);
      drive(0, 0, 0, 1, 0);
      chk_all(106, 12'h000, 12'h000, 4'd0, 1, 0, 0, 3'd2, 1);
      drive(0, 0, 0, 0, 0);
      chk_all(107, 12'h000, 12'h000, 4'd0, 0, 1, 0, 3'd2, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
